// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus iterative shift-add
// multiply and restoring divide, with registered results held between operations.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [3:0]       ALUControl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] HiResult,
  output logic             Zero,
  output logic [1:0]       o_dbg_state
);

  // Handshake: start is taken only on a rising edge while the FSM is IDLE and is
  // otherwise dropped (never queued). busy is high for the WIDTH iteration cycles
  // of MULU/DIVU; done is a one-cycle pulse marking the cycle results become valid.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [3:0] OP_NOTA = 4'b0000;
  localparam logic [3:0] OP_NOTB = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  state_t           r_state;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_single_lo;
  logic [WIDTH-1:0] w_single_hi;
  logic             w_slt;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;
  logic [WIDTH-1:0] w_div_hi;
  logic [WIDTH-1:0] w_div_lo;
  logic [WIDTH-1:0] w_it_hi;
  logic [WIDTH-1:0] w_it_lo;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_last;

  assign o_dbg_state = r_state;

  assign w_slt = $signed(srcA) < $signed(srcB);

  // Single-cycle results are formed from the live inputs at the acceptance edge.
  always_comb begin
    w_single_lo = '0;
    w_single_hi = '0;
    case (ALUControl)
      OP_NOTA: w_single_lo = ~srcA;
      OP_NOTB: w_single_lo = ~srcB;
      OP_ADD:  w_single_lo = srcA + srcB;
      OP_SUB:  w_single_lo = srcA - srcB;
      OP_AND:  w_single_lo = srcA & srcB;
      OP_OR:   w_single_lo = srcA | srcB;
      OP_XOR:  w_single_lo = srcA ^ srcB;
      OP_SLT:  w_single_lo = {{(WIDTH-1){1'b0}}, w_slt};
      OP_DIVU: begin
        w_single_lo = '1;
        w_single_hi = srcA;
      end
      default: w_single_lo = '0;
    endcase
  end

  // Multiply step: r_hi:r_lo is the partial product, r_lo starts as the multiplier.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
  assign w_mul_hi  = w_mul_sum[WIDTH:1];
  assign w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};

  // Divide step: r_hi is the remainder, r_lo shifts the dividend out and quotient in.
  assign w_rem_sh = {r_hi, r_lo[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_a};
  assign w_qbit   = ~w_diff[WIDTH];
  assign w_div_hi = w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_div_lo = {r_lo[WIDTH-2:0], w_qbit};

  assign w_it_hi    = (r_op == OP_DIVU) ? w_div_hi : w_mul_hi;
  assign w_it_lo    = (r_op == OP_DIVU) ? w_div_lo : w_mul_lo;
  assign w_cnt_next = r_cnt + CNT_W'(1);
  assign w_last     = (w_cnt_next == CNT_W'(WIDTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_a       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ALUResult <= '0;
      HiResult  <= '0;
      Zero      <= 1'b1;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op  <= ALUControl;
            r_hi  <= '0;
            r_cnt <= '0;
            if (ALUControl == OP_MULU) begin
              r_a     <= srcA;
              r_lo    <= srcB;
              busy    <= 1'b1;
              r_state <= S_RUN;
            end else if (ALUControl == OP_DIVU && srcB != '0) begin
              r_a     <= srcB;
              r_lo    <= srcA;
              busy    <= 1'b1;
              r_state <= S_RUN;
            end else begin
              r_a       <= srcA;
              r_lo      <= srcB;
              ALUResult <= w_single_lo;
              HiResult  <= w_single_hi;
              Zero      <= (w_single_lo == '0);
              done      <= 1'b1;
              r_state   <= S_FIN;
            end
          end
        end
        S_RUN: begin
          r_hi  <= w_it_hi;
          r_lo  <= w_it_lo;
          r_cnt <= w_cnt_next;
          if (w_last) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            ALUResult <= w_it_lo;
            HiResult  <= w_it_hi;
            Zero      <= (w_it_lo == '0);
            r_state   <= S_FIN;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): directed vector table, multi-cycle
// corner sequences, and randomized operations against an arithmetic reference model.
module tb_alu_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic [3:0]  ALUControl;
  logic        busy;
  logic        done;
  logic [31:0] ALUResult;
  logic [31:0] HiResult;
  logic        Zero;
  logic [1:0]  o_dbg_state;

  int n_checks;
  int n_errors;

  alu_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .srcA       (srcA),
    .srcB       (srcB),
    .ALUControl (ALUControl),
    .busy       (busy),
    .done       (done),
    .ALUResult  (ALUResult),
    .HiResult   (HiResult),
    .Zero       (Zero),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    int          exp_lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: results straight from the operation definitions.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       output logic [31:0] lo, output logic [31:0] hi, output int lat);
    logic [63:0] p;
    lo  = 32'd0;
    hi  = 32'd0;
    lat = 1;
    case (op)
      4'd0: lo = ~a;
      4'd1: lo = ~b;
      4'd2: lo = a + b;
      4'd6: lo = a - b;
      4'd3: lo = a & b;
      4'd4: lo = a | b;
      4'd5: lo = a ^ b;
      4'd7: lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8: begin
        p   = {32'd0, a} * {32'd0, b};
        lo  = p[31:0];
        hi  = p[63:32];
        lat = 33;
      end
      4'd9: begin
        if (b == 32'd0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else begin
          lo  = a / b;
          hi  = a % b;
          lat = 33;
        end
      end
      default: lo = 32'd0;
    endcase
  endtask

  // driver: issue one op, wait for done (bounded), check results/latency/busy
  task automatic run_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input int exp_lat, input bit skip_wait);
    int  lat;
    int  busy_cyc;
    bit  got;
    if (!skip_wait) @(negedge clk);
    srcA = a;
    srcB = b;
    ALUControl = op;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    busy_cyc = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cyc++;
      if (done) got = 1'b1;
    end
    if (!got) begin
      check({name, "_timeout"}, 64'd1, 64'd0);
    end else begin
      check({name, "_lat"}, 64'(lat), 64'(exp_lat));
      check({name, "_busy"}, 64'(busy_cyc), 64'((exp_lat == 33) ? 32 : 0));
      check({name, "_lo"}, 64'(ALUResult), 64'(exp_lo));
      check({name, "_hi"}, 64'(HiResult), 64'(exp_hi));
      check({name, "_zero"}, 64'(Zero), 64'(exp_lo == 32'd0));
    end
    @(negedge clk);
    check({name, "_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n_done;
    int done_lat;
    logic [31:0] ra, rb, elo, ehi;
    logic [3:0]  rop;
    int          elat;

    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    start = 1'b0;
    srcA = '0;
    srcB = '0;
    ALUControl = '0;

    vecs[0]  = '{"add_wrap",  32'hFFFF_FFFF, 32'h1,         4'b0010, 32'h0,         32'h0,         1};
    vecs[1]  = '{"mulu_max",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1000, 32'h1,         32'hFFFF_FFFE, 33};
    vecs[2]  = '{"divu_100_7",32'd100,       32'd7,         4'b1001, 32'd14,        32'd2,         33};
    vecs[3]  = '{"divu_zero", 32'h1234,      32'h0,         4'b1001, 32'hFFFF_FFFF, 32'h1234,      1};
    vecs[4]  = '{"slt_neg",   32'h8000_0000, 32'h1,         4'b0111, 32'h1,         32'h0,         1};
    vecs[5]  = '{"slt_pos",   32'h1,         32'h8000_0000, 4'b0111, 32'h0,         32'h0,         1};
    vecs[6]  = '{"sub_wrap",  32'd5,         32'd7,         4'b0110, 32'hFFFF_FFFE, 32'h0,         1};
    vecs[7]  = '{"nota",      32'h0F0F_0000, 32'h0,         4'b0000, 32'hF0F0_FFFF, 32'h0,         1};
    vecs[8]  = '{"notb",      32'h0,         32'h1234_5678, 4'b0001, 32'hEDCB_A987, 32'h0,         1};
    vecs[9]  = '{"and",       32'hFF00_FF00, 32'h0FF0_0FF0, 4'b0011, 32'h0F00_0F00, 32'h0,         1};
    vecs[10] = '{"or",        32'hFF00_FF00, 32'h0FF0_0FF0, 4'b0100, 32'hFFF0_FFF0, 32'h0,         1};
    vecs[11] = '{"xor",       32'hFF00_FF00, 32'h0FF0_0FF0, 4'b0101, 32'hF0F0_F0F0, 32'h0,         1};
    vecs[12] = '{"bad_op",    32'h1234_5678, 32'h1,         4'b1111, 32'h0,         32'h0,         1};
    vecs[13] = '{"mulu_small",32'd3,         32'd5,         4'b1000, 32'd15,        32'h0,         33};
    vecs[14] = '{"divu_lt",   32'd5,         32'd9,         4'b1001, 32'd0,         32'd5,         33};
    vecs[15] = '{"mulu_hi",   32'h0001_0000, 32'h0001_0000, 4'b1000, 32'h0,         32'h1,         33};

    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_lo",   64'(ALUResult), 64'd0);
    check("rst_hi",   64'(HiResult), 64'd0);
    check("rst_zero", 64'(Zero), 64'd1);
    reset = 1'b0;

    for (int i = 0; i < 16; i++)
      run_vec(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].op,
              vecs[i].exp_lo, vecs[i].exp_hi, vecs[i].exp_lat, 1'b0);

    // start pulsed mid-MULU and during done: neither may be accepted
    @(negedge clk);
    srcA = 32'hFFFF_FFFF;
    srcB = 32'hFFFF_FFFF;
    ALUControl = 4'b1000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_done = 0;
    done_lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        done_lat = c;
      end
      if (c == 5 || done) begin
        srcA = 32'd1;
        srcB = 32'd2;
        ALUControl = 4'b0010;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    check("ign_ndone", 64'(n_done), 64'd1);
    check("ign_lat",   64'(done_lat), 64'd33);
    check("ign_lo",    64'(ALUResult), 64'h1);
    check("ign_hi",    64'(HiResult), 64'hFFFF_FFFE);

    // reset at cycle 10 of a MULU aborts it; ADD accepted on first edge after release
    @(negedge clk);
    srcA = 32'hDEAD_BEEF;
    srcB = 32'd3;
    ALUControl = 4'b1000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_lo",   64'(ALUResult), 64'd0);
    check("abort_hi",   64'(HiResult), 64'd0);
    check("abort_zero", 64'(Zero), 64'd1);
    n_done = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("abort_quiet", 64'(n_done), 64'd0);
    reset = 1'b0;
    run_vec("post_rst_add", 32'd2, 32'd3, 4'b0010, 32'd5, 32'd0, 1, 1'b1);

    // randomized operations against the reference model
    for (int i = 0; i < 150; i++) begin
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
      rop = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) rop = 4'($urandom_range(8, 9));
      model(ra, rb, rop, elo, ehi, elat);
      run_vec("rnd", ra, rb, rop, elo, ehi, elat, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
